// File: rtl/poly_mixer.sv
// Polyphonic voice mixer: per-channel envelope gains, serial multiply-accumulate,
// then a bit-serial restoring divide that normalizes the mix by the total gain.

module poly_mixer_gain #(
    parameter int GW = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          step,
    input  logic          key,
    output logic [GW-1:0] gain
);
    localparam logic [GW-1:0] MAXG = {GW{1'b1}};

    always_ff @(posedge clk) begin
        if (n_rst) begin
            gain <= '0;
        end else if (step) begin
            if (key && gain != MAXG)
                gain <= gain + 1'b1;
            else if (!key && gain != '0)
                gain <= gain - 1'b1;
        end
    end
endmodule

module poly_mixer #(
    parameter int NCH = 12,
    parameter int SW  = 8,
    parameter int GW  = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NCH*SW-1:0] sample_in,
    input  logic [NCH-1:0]    key_on,
    input  logic              start,
    output logic [SW-1:0]     mix_out,
    output logic              mix_valid,
    output logic              busy
);
    localparam int CHW = $clog2(NCH);
    localparam int AW  = SW + GW + CHW;
    localparam int GSW = GW + CHW;
    localparam int BW  = $clog2(AW);

    localparam logic [SW-1:0]  MID      = {1'b1, {(SW-1){1'b0}}};
    localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(AW - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

    state_t state, state_nxt;

    logic [NCH-1:0][SW-1:0] samp;
    logic [NCH-1:0][GW-1:0] g;
    logic [AW-1:0]          acc;
    logic [GSW-1:0]         gsum;
    logic [GSW-1:0]         rem;
    logic [CHW-1:0]         ch;
    logic [BW-1:0]          bcnt;
    logic                   accept;

    assign accept = (state == IDLE) && start;

    // Gains step once per accepted frame, so ACCUM already sees the new values.
    for (genvar i = 0; i < NCH; i++) begin : g_gain
        poly_mixer_gain #(.GW(GW)) u_gain (
            .clk   (clk),
            .n_rst (n_rst),
            .step  (accept),
            .key   (key_on[i]),
            .gain  (g[i])
        );
    end

    logic [SW+GW-1:0] prod;
    assign prod = samp[ch] * g[ch];

    // acc doubles as the quotient shift register during DIVIDE.
    logic [GSW:0]   div_sh;
    logic [GSW-1:0] div_diff;
    logic [GSW-1:0] div_rem;
    logic           div_ge;
    logic [AW-1:0]  div_q;

    always_comb begin
        div_sh   = {rem, acc[AW-1]};
        div_ge   = div_sh >= {1'b0, gsum};
        div_diff = div_sh[GSW-1:0] - gsum;
        div_rem  = div_ge ? div_diff : div_sh[GSW-1:0];
        div_q    = {acc[AW-2:0], div_ge};
    end

    always_ff @(posedge clk) begin
        if (n_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (ch == CH_LAST) state_nxt = DIVIDE;
            DIVIDE:  if (bcnt == BIT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mix_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            samp    <= '0;
            acc     <= '0;
            gsum    <= '0;
            rem     <= '0;
            ch      <= '0;
            bcnt    <= '0;
            mix_out <= MID;
        end else begin
            case (state)
                IDLE: if (start) begin
                    samp <= sample_in;
                    acc  <= '0;
                    gsum <= '0;
                    ch   <= '0;
                end
                ACCUM: begin
                    acc  <= acc + {{CHW{1'b0}}, prod};
                    gsum <= gsum + {{CHW{1'b0}}, g[ch]};
                    if (ch == CH_LAST) begin
                        ch   <= '0;
                        rem  <= '0;
                        bcnt <= '0;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                DIVIDE: begin
                    acc  <= div_q;
                    rem  <= div_rem;
                    bcnt <= bcnt + 1'b1;
                    // Quotient fits SW bits since acc <= max_sample * gsum.
                    if (bcnt == BIT_LAST)
                        mix_out <= (gsum == '0) ? MID : div_q[SW-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/poly_mixer.md
POLY_MIXER -- requirements
Module: poly_mixer

Interface
REQ-001 SHALL have parameter NCH, default 12, number of voice channels (2..16).
REQ-002 SHALL have parameter SW, default 8, unsigned sample width.
REQ-003 SHALL have parameter GW, default 4, per-channel envelope gain width.
REQ-004 SHALL have port clk  input  1  system clock; single clock domain, all logic on posedge.
REQ-005 SHALL have port n_rst  input  1  reset, synchronous, active-high (a 1 sampled on a clk edge resets).
REQ-006 SHALL have port sample_in  input  NCH*SW  packed channel samples; channel i occupies bits [i*SW +: SW].
REQ-007 SHALL have port key_on  input  NCH  per-channel key held (1) / released (0).
REQ-008 SHALL have port start  input  1  frame request, one-cycle pulse at the sample rate.
REQ-009 SHALL have port mix_out  output  SW  normalized mixed sample, held between frames.
REQ-010 SHALL have port mix_valid  output  1  one-cycle pulse when mix_out updates.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL hold gain register g[i] (GW bits, unsigned) per channel; MAXG = 2^GW-1.
REQ-013 SHALL derive AW = SW+GW+clog2(NCH) for the accumulator and GSW = GW+clog2(NCH) for the gain sum.
REQ-014 SHALL use states IDLE, ACCUM, DIVIDE, DONE; busy = 1 in every state except IDLE.
REQ-015 SHALL accept start only in IDLE; start in any other state is ignored with no side effect.
REQ-016 On accept (cycle 0): latch all sample_in, clear accumulator and gain sum, enter ACCUM.
REQ-017 On accept, per channel: g[i] +1, saturating at MAXG, if key_on[i]=1; else g[i] -1, floored at 0.
REQ-018 SHALL use the updated gains (REQ-017) for the frame being accepted.
REQ-019 ACCUM SHALL process one channel per cycle, index 0..NCH-1: acc += sample[i]*g[i], gsum += g[i]; NCH cycles.
REQ-020 DIVIDE SHALL perform restoring division acc/gsum, one quotient bit per cycle, AW cycles.
REQ-021 Quotient SHALL be truncated (floor); its upper AW-SW bits are always 0 and SW bits go to mix_out.
REQ-022 If gsum = 0, mix_out SHALL be 2^(SW-1) (silence midpoint); timing is unchanged.
REQ-023 DONE SHALL last one cycle: mix_out updated, mix_valid = 1, return to IDLE.
REQ-024 mix_valid SHALL assert exactly NCH+AW+1 cycles after the accepting edge; with defaults, 29 cycles.
REQ-025 A start asserted in the cycle after DONE (IDLE) SHALL be accepted; back-to-back frames are allowed.
REQ-026 key_on changes during a frame SHALL take effect only at the next accept.
REQ-027 mix_out SHALL change only in DONE and on reset.

Reset
REQ-028 On n_rst: state IDLE, busy 0, mix_valid 0, mix_out 2^(SW-1), all g[i] 0, acc 0, gsum 0.
REQ-029 Reset mid-frame SHALL abort the frame with no mix_valid pulse; reset has priority over start.

Verification (NCH=12, SW=8, GW=4)
REQ-030 Reset, all keys off, one start -> mix_valid pulse exactly 29 cycles later, mix_out=128, busy high for cycles 1..29.
REQ-031 key_on[0]=1 only, sample0=200, one start -> g0=1, mix_out=200; after 20 starts g0=15 and saturates, mix_out=200.
REQ-032 Keys 0,1 held 15 frames, sample0=100, sample1=200 -> mix_out=150; release key1 for one frame -> (1500+2800)/29 -> mix_out=148.
REQ-033 start pulses at cycles 5 and 20 after an accepted start -> ignored; exactly one mix_valid, gains stepped once.
REQ-034 n_rst asserted during ACCUM -> no mix_valid, mix_out=128, gains 0; next start is processed normally.
REQ-035 All keys released after saturation, 15 starts -> gains reach 0, final mix_out=128, no underflow on the 16th start.
